// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus for the MEM stage
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: issues data-memory accesses and registers the MEM/WB payload
module mem_access_stage (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                write_back_ctrl_sgnl,
    input  logic [15:0]                memory_ctrl_sgnl,
    input  logic [15:0]                alu_result_top_half,
    input  logic [15:0]                alu_result_bottom_half,
    input  logic [15:0]                inst_buff_in,
    mem_access_stage_if.master         mem_bus,
    output logic                       stall,
    output logic [15:0]                wb_ctrl_out,
    output logic [15:0]                read_data_out,
    output logic [15:0]                alu_result_out,
    output logic [15:0]                inst_out,
    output logic                       valid_out,
    output logic                       mem_err
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [15:0] r_wb_lat, r_alu_lat, r_inst_lat;
    logic        r_mem_req, r_mem_we;
    logic [15:0] r_mem_addr, r_mem_wdata;
    logic [15:0] r_wb_ctrl, r_read_data, r_alu_result, r_inst;
    logic        r_valid, r_mem_err;

    logic w_is_mem_op;
    logic w_timeout;
    logic w_unused_ctrl;

    assign w_is_mem_op   = memory_ctrl_sgnl[0] | memory_ctrl_sgnl[1];
    // Ack wins over timeout, so the timeout only fires when ack is absent.
    assign w_timeout     = (r_wait_cnt == 4'hF) && !mem_bus.mem_ack;
    assign w_unused_ctrl = ^memory_ctrl_sgnl[15:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_is_mem_op) w_next_state = ACCESS;
            ACCESS:  if (mem_bus.mem_ack || w_timeout) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt   <= 4'h0;
            r_wb_lat     <= 16'h0;
            r_alu_lat    <= 16'h0;
            r_inst_lat   <= 16'h0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 16'h0;
            r_mem_wdata  <= 16'h0;
            r_wb_ctrl    <= 16'h0;
            r_read_data  <= 16'h0;
            r_alu_result <= 16'h0;
            r_inst       <= 16'h0;
            r_valid      <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_is_mem_op) begin
                        r_wb_lat    <= write_back_ctrl_sgnl;
                        r_alu_lat   <= alu_result_bottom_half;
                        r_inst_lat  <= inst_buff_in;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= memory_ctrl_sgnl[1];
                        r_mem_addr  <= alu_result_bottom_half;
                        r_mem_wdata <= alu_result_top_half;
                        r_wait_cnt  <= 4'h0;
                    end else begin
                        r_wb_ctrl    <= write_back_ctrl_sgnl;
                        r_alu_result <= alu_result_bottom_half;
                        r_inst       <= inst_buff_in;
                        r_valid      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_bus.mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_wb_ctrl    <= r_wb_lat;
                        r_alu_result <= r_alu_lat;
                        r_inst       <= r_inst_lat;
                        if (!r_mem_we) r_read_data <= mem_bus.mem_rdata;
                        r_valid      <= 1'b1;
                    end else if (w_timeout) begin
                        // Poisoned result: write-back suppressed, data marked all-ones.
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_err    <= 1'b1;
                        r_read_data  <= 16'hFFFF;
                        r_wb_ctrl    <= 16'h0000;
                        r_alu_result <= r_alu_lat;
                        r_inst       <= r_inst_lat;
                        r_valid      <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall             = (r_state == ACCESS);
    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_wdata = r_mem_wdata;
    assign wb_ctrl_out       = r_wb_ctrl;
    assign read_data_out     = r_read_data;
    assign alu_result_out    = r_alu_result;
    assign inst_out          = r_inst;
    assign valid_out         = r_valid;
    assign mem_err           = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized bench for mem_access_stage with an operation-level model
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_in, ctrl_in, top_in, bot_in, inst_in;
    logic        stall, valid_out, mem_err;
    logic [15:0] wb_ctrl_out, read_data_out, alu_result_out, inst_out;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .write_back_ctrl_sgnl   (wb_in),
        .memory_ctrl_sgnl       (ctrl_in),
        .alu_result_top_half    (top_in),
        .alu_result_bottom_half (bot_in),
        .inst_buff_in           (inst_in),
        .mem_bus                (bus),
        .stall                  (stall),
        .wb_ctrl_out            (wb_ctrl_out),
        .read_data_out          (read_data_out),
        .alu_result_out         (alu_result_out),
        .inst_out               (inst_out),
        .valid_out              (valid_out),
        .mem_err                (mem_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] m_wb, m_rd, m_alu, m_inst;
    logic        m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        wb_in   = 16'($urandom);
        ctrl_in = 16'($urandom);
        top_in  = 16'($urandom);
        bot_in  = 16'($urandom);
        inst_in = 16'($urandom);
    endtask

    task automatic chk_payload(input string tag);
        chk({tag, ".valid"}, valid_out,      1'b1);
        chk({tag, ".stall"}, stall,          1'b0);
        chk({tag, ".req"},   bus.mem_req,    1'b0);
        chk({tag, ".wb"},    wb_ctrl_out,    m_wb);
        chk({tag, ".rd"},    read_data_out,  m_rd);
        chk({tag, ".alu"},   alu_result_out, m_alu);
        chk({tag, ".inst"},  inst_out,       m_inst);
        chk({tag, ".err"},   mem_err,        m_err);
    endtask

    // ack_at: index of the ACCESS edge carrying mem_ack; anything above 15 never acks.
    task automatic do_op(input string tag, input logic [15:0] ctrl, input logic [15:0] top,
                         input logic [15:0] bot, input logic [15:0] wb, input logic [15:0] inst,
                         input logic [15:0] rdata, input int ack_at, input logic entry_ack);
        logic is_mem, is_write;
        is_mem   = (ctrl[1:0] != 2'b00);
        is_write = ctrl[1];
        wb_in = wb; ctrl_in = ctrl; top_in = top; bot_in = bot; inst_in = inst;
        bus.mem_ack   = entry_ack;
        bus.mem_rdata = 16'($urandom);
        step();
        if (!is_mem) begin
            m_wb = wb; m_alu = bot; m_inst = inst;
            chk_payload({tag, ".alu_op"});
        end else begin
            chk({tag, ".entry.stall"}, stall,         1'b1);
            chk({tag, ".entry.req"},   bus.mem_req,   1'b1);
            chk({tag, ".entry.we"},    bus.mem_we,    is_write);
            chk({tag, ".entry.addr"},  bus.mem_addr,  bot);
            chk({tag, ".entry.wdata"}, bus.mem_wdata, top);
            chk({tag, ".entry.valid"}, valid_out,     1'b0);
            for (int k = 0; k < 16; k++) begin
                scramble_inputs();
                bus.mem_ack   = (k == ack_at);
                bus.mem_rdata = (k == ack_at) ? rdata : 16'($urandom);
                step();
                if (k == ack_at) begin
                    m_wb = wb; m_alu = bot; m_inst = inst;
                    if (!is_write) m_rd = rdata;
                    chk_payload({tag, ".ack"});
                    chk({tag, ".ack.we"}, bus.mem_we, 1'b0);
                    break;
                end else if (k == 15) begin
                    m_err = 1'b1; m_rd = 16'hFFFF; m_wb = 16'h0000; m_alu = bot; m_inst = inst;
                    chk_payload({tag, ".timeout"});
                    break;
                end else begin
                    chk({tag, ".wait.stall"}, stall,         1'b1);
                    chk({tag, ".wait.req"},   bus.mem_req,   1'b1);
                    chk({tag, ".wait.we"},    bus.mem_we,    is_write);
                    chk({tag, ".wait.addr"},  bus.mem_addr,  bot);
                    chk({tag, ".wait.wdata"}, bus.mem_wdata, top);
                    chk({tag, ".wait.valid"}, valid_out,     1'b0);
                end
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, stall,          1'b0);
        chk({tag, ".req"},   bus.mem_req,    1'b0);
        chk({tag, ".we"},    bus.mem_we,     1'b0);
        chk({tag, ".addr"},  bus.mem_addr,   16'h0);
        chk({tag, ".wdata"}, bus.mem_wdata,  16'h0);
        chk({tag, ".valid"}, valid_out,      1'b0);
        chk({tag, ".err"},   mem_err,        1'b0);
        chk({tag, ".wb"},    wb_ctrl_out,    16'h0);
        chk({tag, ".rd"},    read_data_out,  16'h0);
        chk({tag, ".alu"},   alu_result_out, 16'h0);
        chk({tag, ".inst"},  inst_out,       16'h0);
    endtask

    initial begin
        logic [15:0] c;
        rst = 1'b0;
        wb_in = 16'h0; ctrl_in = 16'h0; top_in = 16'h0; bot_in = 16'h0; inst_in = 16'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
        m_wb = 16'h0; m_rd = 16'h0; m_alu = 16'h0; m_inst = 16'h0; m_err = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;

        do_op("alu",      16'h0000, 16'h0000, 16'h1234, 16'h00C3, 16'hA001, 16'h0000, 0, 1'b1);
        do_op("load",     16'h0001, 16'h0000, 16'h0040, 16'h0081, 16'hB002, 16'hBEEF, 2, 1'b0);
        chk("load.after.stall", stall, 1'b0);
        do_op("store",    16'h0002, 16'h5555, 16'h0010, 16'h0042, 16'hC003, 16'h1111, 0, 1'b0);
        do_op("conflict", 16'h0003, 16'hAAAA, 16'h0020, 16'h0011, 16'hD004, 16'h2222, 4, 1'b0);
        do_op("timeout",  16'h0001, 16'h0000, 16'h0050, 16'h00FF, 16'hE005, 16'h3333, 99, 1'b0);
        do_op("post_to",  16'h0000, 16'h0000, 16'h7777, 16'h0001, 16'hF006, 16'h0000, 0, 1'b0);
        do_op("ack15",    16'h0001, 16'h0000, 16'h0060, 16'h0033, 16'h1007, 16'hCAFE, 15, 1'b0);

        // Reset during the second ACCESS cycle must abort without a valid pulse.
        wb_in = 16'h0044; ctrl_in = 16'h0001; top_in = 16'h0; bot_in = 16'h0070; inst_in = 16'h2008;
        step();
        chk("rst_mid.entry.stall", stall, 1'b1);
        step();
        chk("rst_mid.second.req", bus.mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        m_wb = 16'h0; m_rd = 16'h0; m_alu = 16'h0; m_inst = 16'h0; m_err = 1'b0;
        step();
        rst = 1'b1;
        do_op("post_rst", 16'h0001, 16'h0000, 16'h0080, 16'h0055, 16'h3009, 16'h4444, 1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            c = 16'($urandom);
            if ($urandom_range(0, 2) == 0) c[1:0] = 2'b00;
            do_op($sformatf("rand%0d", i), c, 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 write_back_ctrl_sgnl  input  16  write-back control from the EX/MEM buffer.
REQ-005 memory_ctrl_sgnl  input  16  memory control: bit0 mem_read, bit1 mem_write, bits 15:2 ignored.
REQ-006 alu_result_top_half  input  16  store data.
REQ-007 alu_result_bottom_half  input  16  memory address, or the ALU result for non-memory operations.
REQ-008 inst_buff_in  input  16  instruction word.
REQ-009 mem_req, mem_we  output  1 each  data-memory request and write enable.
REQ-010 mem_addr, mem_wdata  output  16 each  data-memory address and write data.
REQ-011 mem_rdata  input  16  read data, valid only while mem_ack=1.
REQ-012 mem_ack  input  1  memory completion strobe.
REQ-013 stall  output  1  hold request to upstream stages.
REQ-014 wb_ctrl_out, read_data_out, alu_result_out, inst_out  output  16 each  registered MEM/WB payload.
REQ-015 valid_out  output  1  payload updated this cycle.
REQ-016 mem_err  output  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have two states: IDLE and ACCESS. Every output other than stall SHALL be a register.
REQ-018 stall SHALL equal (state==ACCESS) combinationally.
REQ-019 In IDLE, each rising edge SHALL sample all inputs.
- Non-memory operation (bits 1:0 = 00): on that edge, load wb_ctrl_out, alu_result_out (= bottom half) and inst_out; hold read_data_out; set valid_out=1. Latency is 1 cycle.
REQ-020 In IDLE, a memory operation (bit0 or bit1 = 1) SHALL, on that edge:
- latch write_back_ctrl_sgnl, alu_result_bottom_half and inst_buff_in internally;
- set mem_req=1, mem_addr=bottom half, mem_wdata=top half, mem_we=bit1;
- set valid_out=0 and enter ACCESS.
REQ-021 If bit0 and bit1 are both 1, the operation SHALL be treated as a write (mem_we=1) and the read SHALL be ignored.
REQ-022 In ACCESS, inputs SHALL be ignored, and mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until exit.
REQ-023 In ACCESS with mem_ack=1 at an edge, the block SHALL on that edge:
- clear mem_req and mem_we;
- load the payload from the latched values;
- load read_data_out=mem_rdata for a read, and hold read_data_out for a write;
- set valid_out=1 and return to IDLE.
REQ-024 A 4-bit wait counter SHALL clear on ACCESS entry and increment on each ACCESS edge without mem_ack.
REQ-025 Timeout: at the edge where the counter equals 15 and mem_ack=0, the block SHALL:
- clear mem_req;
- set mem_err=1, read_data_out=16'hFFFF, wb_ctrl_out=16'h0000 (suppress write-back);
- load alu_result_out and inst_out from the latched values;
- set valid_out=1 and return to IDLE.
REQ-026 mem_ack SHALL be honoured on the timeout edge itself: ack takes priority over timeout.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 valid_out SHALL be a single-cycle pulse per completed operation and SHALL be 0 in every other cycle.
REQ-029 mem_err SHALL clear only on reset.
REQ-030 The block SHALL accept a new operation on the first IDLE edge after returning from ACCESS, so back-to-back memory operations are each 2 cycles minimum.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE and counter=0.
REQ-032 rst=0 SHALL immediately force every output to 0, including stall, mem_req and mem_err.
REQ-033 Reset asserted during ACCESS SHALL abort the access with no valid_out pulse; a later mem_ack SHALL be ignored.

Verification
REQ-034 ALU op: memory_ctrl=0, bottom=16'h1234, inst=16'hA001 -> after 1 edge: alu_result_out=1234, inst_out=A001, valid_out=1, stall=0, mem_req=0.
REQ-035 Load with ack delayed 3 cycles: memory_ctrl=1, bottom=16'h0040, mem_rdata=16'hBEEF -> mem_req=1 and stall=1 for 3 cycles, mem_addr=0040, mem_we=0; on the ack edge read_data_out=BEEF and valid_out=1; stall=0 the next cycle.
REQ-036 Store with immediate ack: memory_ctrl=2, top=16'h5555, bottom=16'h0010 -> mem_we=1, mem_wdata=5555, mem_addr=0010; ack on the next edge -> valid_out=1, read_data_out unchanged.
REQ-037 Timeout: load with ack never asserted -> after 16 ACCESS edges mem_err=1, read_data_out=FFFF, wb_ctrl_out=0000, valid_out=1; mem_err stays 1 across later operations.
REQ-038 Reset mid-access: rst=0 during the second ACCESS cycle -> mem_req, stall and valid_out go 0 immediately; a mem_ack after reset release produces no valid_out.
REQ-039 Read/write conflict: memory_ctrl=3 -> mem_we=1 for the whole access.
